spi_flash_resp: RTL
===================

// Module: spi_flash_resp
// PURPOSE
//  SPI mode-0 responder (slave) that emulates a small serial NOR flash in front of the SoC SPI0 master.
//  Its pins are fpioa[2..5]: cs, miso, mosi, clk. It is the far end of the SoC's SPI master path.
//  Use it as a synthesizable stand-in for the external flash model in system sims, and on FPGA builds without flash.
//  Contents are held in an internal byte RAM. A system-side sideband port preloads the RAM and inspects it.
// PARAMETERS
//  MEM_AW    12         byte-address width of internal RAM (depth 2**MEM_AW)
//  JEDEC_ID  24'hEF4018 bytes returned by opcode 9F, MSB first
// PORTS
//  clk          in   1        system clock; SCK must be <= clk/8
//  rst          in   1        synchronous, active-high reset
//  spi_cs_i     in   1        chip select, active low, asynchronous to clk
//  spi_clk_i    in   1        SCK, asynchronous to clk
//  spi_mosi_i   in   1        master out
//  spi_miso_o   out  1        slave out
//  spi_miso_oe  out  1        MISO drive enable (1 while cs low)
//  sys_we_i     in   1        sideband byte write
//  sys_addr_i   in   MEM_AW   sideband address
//  sys_wdata_i  in   8        sideband write data
//  sys_rdata_o  out  8        sideband read data, 1-cycle latency
//  wr_pulse_o   out  1        1-clk pulse per byte committed by SPI page program
// BEHAVIOUR
//  - Reset values:
//    - outputs: spi_miso_o=0, spi_miso_oe=0, sys_rdata_o=0, wr_pulse_o=0.
//    - internal: state=IDLE, WEL=0. RAM contents are not reset.
//  - Input sampling: cs, clk and mosi each pass through a 2-FF synchronizer.
//  - Edge detection: SCK rise/fall is detected on the synchronized level.
//  - MOSI is sampled on SCK rise. MISO is updated on SCK fall.
//  - Bits are MSB first. A bit counter 0..7 forms bytes.
//  - CS high (synchronized) at any time:
//    - state goes to IDLE and the bit counter clears; spi_miso_oe=0 the next clk.
//    - a partial byte is discarded.
//  - States:
//    - IDLE: waits for cs low, then goes to CMD.
//    - CMD: takes the 8-bit opcode.
//      - 03 -> ADDR
//      - 02 -> ADDR if WEL=1, else IGNORE
//      - 06 -> sets WEL, then IGNORE
//      - 04 -> clears WEL, then IGNORE
//      - 05 -> STAT
//      - 9F -> ID
//      - any other opcode -> IGNORE
//    - ADDR: takes 24 bits. Only bits [MEM_AW-1:0] are kept. Then goes to RD (03) or WR (02).
//    - RD: streams RAM[addr], addr+1, ...
//      - The next byte is fetched when bit 0 of the current byte is driven.
//      - The address wraps modulo 2**MEM_AW.
//    - WR: each complete MOSI byte is written to RAM[addr]; wr_pulse_o fires and addr increments (same wrap).
//      - At cs rise after any 02 command, WEL clears.
//    - STAT: repeats {6'b0, WEL, 1'b0} until cs rises.
//    - ID: sends JEDEC_ID bytes [23:16], [15:8], [7:0], then 8'h00 until cs rises.
//    - IGNORE: MISO=0 and MOSI is ignored until cs rises.
//  - Response timing: the MSB of the first response byte is on MISO at the SCK fall that follows the last command/address bit rise.
//  - Sideband port:
//    - a write is applied at the clk edge; the read returns RAM[sys_addr_i] on the next clk.
//    - If an SPI commit and sys_we_i hit the same address in the same clk, the SPI write wins and the sideband write is dropped.
// CONFIGURATION
//  - SPI_FLASH_RESP_FASTRD_EN defined:
//    - adds opcode 0B (fast read): ADDR, then DUMMY (8 SCK cycles, MISO=0), then RD.
//  - Macro undefined: 0B decodes to IGNORE.
// STRUCTURE
//  - Package spi_flash_resp_pkg:
//    - opcode localparams OP_READ=8'h03, OP_PP=8'h02, OP_WREN=8'h06, OP_WRDI=8'h04, OP_RDSR=8'h05, OP_RDID=8'h9F, OP_FRD=8'h0B
//    - typedef enum logic [3:0] resp_state_t {IDLE, CMD, ADDR, DUMMY, RD, WR, STAT, ID, IGNORE}
//  - Sub-module spi_resp_sync_edge: 2-FF synchronizer plus rise/fall pulse for one input.
//    - Instantiated for cs and clk; mosi uses the sync only.
// TESTING
//  1. Reset: assert rst for 3 clk mid-transfer (cs low, after 12 SCK) -> miso_oe=0, miso=0, state IDLE.
//     After rst drops and a cs high-to-low cycle, a following 9F transfer responds normally.
//  2. Opcode 9F, then 24 SCK -> MISO bytes EF, 40, 18; 8 further SCK -> 00.
//  3. Sideband preload RAM[0x010..0x013]=11,22,33,44; SPI 03 00 00 10, then 32 SCK -> MISO 11 22 33 44.
//     Same read at addr 0xFFF with MEM_AW=12 -> RAM[FFF], then RAM[000].
//  4. Page program:
//     - 02 00 00 20 AA BB without prior 06 -> no write; sideband read of 0x020 unchanged.
//     - 06 (cs pulse), then 05 -> status 02.
//     - 02 00 00 20 AA BB -> two wr_pulse_o; sideband reads 0x020=AA, 0x021=BB.
//     - 05 afterwards -> status 00.
//  5. Abort: 02 write raising cs after 4 bits of the data byte -> no wr_pulse_o, RAM unchanged.
//  6. Collision: SPI commit to 0x030 (data 5A) in the same clk as sys_we_i to 0x030 (data C3) -> RAM[0x030]=5A.
//  7. FASTRD_EN only: 0B 00 00 10, then 8 dummy SCK -> MISO 11 on the following byte.

Source files
------------

// File: rtl/spi_flash_resp_pkg.sv
// -----------------------------------------------------------------------------
// spi_flash_resp_pkg
//   Shared definitions for the SPI NOR-flash responder.
//   - opcode constants understood by the responder
//   - resp_state_t : protocol state of the responder FSM
//   - decode_op()  : maps a received opcode (and current WEL) to the next state
//   Optional feature macro: SPI_FLASH_RESP_FASTRD_EN (adds opcode 0B fast read).
// -----------------------------------------------------------------------------
package spi_flash_resp_pkg;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_WRDI = 8'h04;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam logic [7:0] OP_FRD  = 8'h0B;

  typedef enum logic [3:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    RD,
    WR,
    STAT,
    ID,
    IGNORE
  } resp_state_t;

  // State entered after the last opcode bit. Program without WEL is dropped.
  function automatic resp_state_t decode_op(input logic [7:0] op, input logic wel);
    resp_state_t nxt;
    case (op)
      OP_READ: nxt = ADDR;
      OP_PP:   nxt = wel ? ADDR : IGNORE;
      OP_RDSR: nxt = STAT;
      OP_RDID: nxt = ID;
`ifdef SPI_FLASH_RESP_FASTRD_EN
      OP_FRD:  nxt = ADDR;
`endif
      default: nxt = IGNORE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/spi_resp_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_resp_sync_edge
//   Two-flop synchronizer for one asynchronous input, plus single-cycle
//   rise/fall pulses derived from the synchronized level.
//   Ports:
//     clk     in   system clock
//     rst     in   synchronous active-high reset (flops load RST_VAL)
//     d_i     in   asynchronous input
//     level_o out  synchronized level
//     rise_o  out  1-clk pulse on synchronized 0->1
//     fall_o  out  1-clk pulse on synchronized 1->0
// -----------------------------------------------------------------------------
module spi_resp_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;
  logic meta_d, sync_d, prev_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_flash_resp.sv
// -----------------------------------------------------------------------------
// spi_flash_resp
//   SPI mode-0 responder emulating a small serial NOR flash. Contents live in
//   an internal byte RAM that a sideband port can preload and inspect.
//   Optional feature macro: SPI_FLASH_RESP_FASTRD_EN (opcode 0B, 8 dummy SCK).
//   Ports:
//     clk          in   system clock (SCK must be <= clk/8)
//     rst          in   synchronous active-high reset
//     spi_cs_i     in   chip select, active low, async
//     spi_clk_i    in   SCK, async
//     spi_mosi_i   in   master out
//     spi_miso_o   out  slave out, changes after SCK fall
//     spi_miso_oe  out  MISO drive enable (while cs low)
//     sys_we_i     in   sideband byte write
//     sys_addr_i   in   sideband address
//     sys_wdata_i  in   sideband write data
//     sys_rdata_o  out  sideband read data, 1-cycle latency
//     wr_pulse_o   out  1-clk pulse per byte committed by page program
//
//   state  | meaning
//   IDLE   | cs high, waiting for cs fall
//   CMD    | shifting in the opcode
//   ADDR   | shifting in 24 address bits (low MEM_AW kept)
//   DUMMY  | 8 SCK of fast-read dummy, MISO low
//   RD     | streaming RAM bytes from addr, incrementing
//   WR     | committing each full MOSI byte to RAM
//   STAT   | repeating status byte {6'b0, WEL, 1'b0}
//   ID     | sending JEDEC_ID bytes, then 00
//   IGNORE | MISO low, MOSI ignored until cs rises
// -----------------------------------------------------------------------------
module spi_flash_resp
  import spi_flash_resp_pkg::*;
#(
  parameter int          MEM_AW   = 12,
  parameter logic [23:0] JEDEC_ID = 24'hEF4018
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cs_i,
  input  logic              spi_clk_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oe,
  input  logic              sys_we_i,
  input  logic [MEM_AW-1:0] sys_addr_i,
  input  logic [7:0]        sys_wdata_i,
  output logic [7:0]        sys_rdata_o,
  output logic              wr_pulse_o
);

  localparam logic [MEM_AW-1:0] ADDR_ONE = MEM_AW'(1);

  logic cs_lvl, cs_rise, cs_fall;
  logic sck_lvl_unused, sck_rise, sck_fall;
  logic mosi_meta_q, mosi_sync_q;

  spi_resp_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk     (clk),
    .rst     (rst),
    .d_i     (spi_cs_i),
    .level_o (cs_lvl),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  spi_resp_sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
    .clk     (clk),
    .rst     (rst),
    .d_i     (spi_clk_i),
    .level_o (sck_lvl_unused),
    .rise_o  (sck_rise),
    .fall_o  (sck_fall)
  );

  // MOSI shares the same two-flop depth so it lines up with the SCK rise pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      mosi_meta_q <= spi_mosi_i;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  resp_state_t       state_q, state_d;
  resp_state_t       after_addr_q, after_addr_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [6:0]        rx_q, rx_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [7:0]        tx_q, tx_d;
  logic              miso_q, miso_d;
  logic              oe_q, oe_d;
  logic              wel_q, wel_d;
  logic              pp_seen_q, pp_seen_d;
  logic [1:0]        id_idx_q, id_idx_d;
  logic              wr_pulse_q, wr_pulse_d;
  logic [7:0]        sys_rdata_q, sys_rdata_d;
  logic [7:0]        spi_rdata_q;
  logic [7:0]        mem_q [2**MEM_AW];

  logic [7:0] rx_byte;
  logic [7:0] resp_byte;
  logic       byte_done;
  logic       spi_we;

  assign rx_byte   = {rx_q, mosi_sync_q};
  assign byte_done = sck_rise & (bit_cnt_q == 3'd7);
  assign spi_we    = ~cs_lvl & (state_q == WR) & byte_done;

  // Byte presented at the first SCK fall of each response byte.
  always_comb begin
    resp_byte = 8'h00;
    case (state_q)
      RD:   resp_byte = spi_rdata_q;
      STAT: resp_byte = {6'b0, wel_q, 1'b0};
      ID: begin
        case (id_idx_q)
          2'd0:    resp_byte = JEDEC_ID[23:16];
          2'd1:    resp_byte = JEDEC_ID[15:8];
          2'd2:    resp_byte = JEDEC_ID[7:0];
          default: resp_byte = 8'h00;
        endcase
      end
      default: resp_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    after_addr_d = after_addr_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    rx_d         = rx_q;
    addr_d       = addr_q;
    tx_d         = tx_q;
    miso_d       = miso_q;
    oe_d         = ~cs_lvl;
    wel_d        = wel_q;
    pp_seen_d    = pp_seen_q;
    id_idx_d     = id_idx_q;
    wr_pulse_d   = 1'b0;

    if (cs_lvl) begin
      // Deselect aborts everything; any partial byte is simply forgotten.
      state_d    = IDLE;
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 2'd0;
      id_idx_d   = 2'd0;
      tx_d       = 8'h00;
      miso_d     = 1'b0;
      pp_seen_d  = 1'b0;
      if (cs_rise && pp_seen_q) begin
        wel_d = 1'b0;
      end
    end else if (state_q == IDLE) begin
      if (cs_fall) begin
        state_d = CMD;
      end
    end else begin
      if (sck_rise) begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        rx_d      = rx_byte[6:0];
        if (state_q == ADDR) begin
          addr_d = {addr_q[MEM_AW-2:0], mosi_sync_q};
        end
        if (bit_cnt_q == 3'd7) begin
          case (state_q)
            CMD: begin
              state_d    = decode_op(rx_byte, wel_q);
              byte_cnt_d = 2'd0;
              if (rx_byte == OP_PP) begin
                after_addr_d = WR;
                pp_seen_d    = 1'b1;
              end else if (rx_byte == OP_FRD) begin
                after_addr_d = DUMMY;
              end else begin
                after_addr_d = RD;
              end
              if (rx_byte == OP_WREN) wel_d = 1'b1;
              if (rx_byte == OP_WRDI) wel_d = 1'b0;
            end
            ADDR: begin
              byte_cnt_d = byte_cnt_q + 2'd1;
              if (byte_cnt_q == 2'd2) begin
                state_d = after_addr_q;
              end
            end
            DUMMY: state_d = RD;
            WR: begin
              addr_d     = addr_q + ADDR_ONE;
              wr_pulse_d = 1'b1;
            end
            default: ;
          endcase
        end
      end

      if (sck_fall) begin
        // bit_cnt counts rises, so 0 here means this fall starts a new byte.
        if (bit_cnt_q == 3'd0) begin
          miso_d = resp_byte[7];
          tx_d   = {resp_byte[6:0], 1'b0};
          if (state_q == ID && id_idx_q != 2'd3) begin
            id_idx_d = id_idx_q + 2'd1;
          end
        end else begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end
        // Bit 0 is going out now: advance so the next byte is read in time.
        if (state_q == RD && bit_cnt_q == 3'd7) begin
          addr_d = addr_q + ADDR_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      after_addr_q <= RD;
      bit_cnt_q    <= 3'd0;
      byte_cnt_q   <= 2'd0;
      rx_q         <= 7'd0;
      addr_q       <= '0;
      tx_q         <= 8'h00;
      miso_q       <= 1'b0;
      oe_q         <= 1'b0;
      wel_q        <= 1'b0;
      pp_seen_q    <= 1'b0;
      id_idx_q     <= 2'd0;
      wr_pulse_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      after_addr_q <= after_addr_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      rx_q         <= rx_d;
      addr_q       <= addr_d;
      tx_q         <= tx_d;
      miso_q       <= miso_d;
      oe_q         <= oe_d;
      wel_q        <= wel_d;
      pp_seen_q    <= pp_seen_d;
      id_idx_q     <= id_idx_d;
      wr_pulse_q   <= wr_pulse_d;
    end
  end

  // RAM: SPI commit takes priority over a sideband write to the same byte.
  always_ff @(posedge clk) begin
    if (sys_we_i && !(spi_we && (sys_addr_i == addr_q))) begin
      mem_q[sys_addr_i] <= sys_wdata_i;
    end
    if (spi_we) begin
      mem_q[addr_q] <= rx_byte;
    end
    spi_rdata_q <= mem_q[addr_q];
  end

  always_comb begin
    sys_rdata_d = mem_q[sys_addr_i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sys_rdata_q <= 8'h00;
    end else begin
      sys_rdata_q <= sys_rdata_d;
    end
  end

  assign spi_miso_o  = miso_q;
  assign spi_miso_oe = oe_q;
  assign sys_rdata_o = sys_rdata_q;
  assign wr_pulse_o  = wr_pulse_q;

endmodule
